iterative_cipher_core: RTL and testbench

ITERATIVE_CIPHER_CORE -- requirements
Module: iterative_cipher_core

---
 rtl/iterative_cipher_core.sv | 149 ++++++++++++++
 tb/tb_iterative_cipher_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_cipher_core.sv
// rtl/iterative_cipher_core.sv - iterative 64-bit SPN cipher core, UNROLL rounds per clock
// Encrypts or decrypts one block per request using a rotating round key.
module iterative_cipher_core #(
  parameter int NUM_ROUNDS = 10,
  parameter int UNROLL     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out
);

  localparam int CW      = $clog2(NUM_ROUNDS + 1);
  localparam int STEPS   = NUM_ROUNDS / UNROLL;
  localparam int DEC_ROT = (4 * NUM_ROUNDS) % 64;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (UNROLL < 1 || NUM_ROUNDS < 1 || NUM_ROUNDS > 31 || (NUM_ROUNDS % UNROLL) != 0) begin : g_param_check
    $error("iterative_cipher_core: illegal NUM_ROUNDS/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t            fsm;
  logic [63:0]     state_q;
  logic [63:0]     kreg_q;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic [63:0]     dec_key;
  logic [63:0]     load_key;
  logic [63:0]     rnd_state;
  logic [63:0]     rnd_key;
  logic            accept;

  function automatic logic [3:0] sbox(input logic [3:0] v);
    case (v)
      4'h0: sbox = 4'h6;  4'h1: sbox = 4'hB;  4'h2: sbox = 4'h0;  4'h3: sbox = 4'h4;
      4'h4: sbox = 4'hD;  4'h5: sbox = 4'h3;  4'h6: sbox = 4'hF;  4'h7: sbox = 4'h8;
      4'h8: sbox = 4'hA;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h7;  4'hB: sbox = 4'hC;
      4'hC: sbox = 4'h5;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'h1;  default: sbox = 4'h9;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] v);
    case (v)
      4'h0: inv_sbox = 4'h2;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'h5;
      4'h4: inv_sbox = 4'h3;  4'h5: inv_sbox = 4'hC;  4'h6: inv_sbox = 4'h0;  4'h7: inv_sbox = 4'hA;
      4'h8: inv_sbox = 4'h7;  4'h9: inv_sbox = 4'hF;  4'hA: inv_sbox = 4'h8;  4'hB: inv_sbox = 4'h1;
      4'hC: inv_sbox = 4'hB;  4'hD: inv_sbox = 4'h4;  4'hE: inv_sbox = 4'hD;  default: inv_sbox = 4'h6;
    endcase
  endfunction

  function automatic logic [63:0] sub_nibbles(input logic [63:0] s, input logic inv);
    logic [63:0] o;
    o = '0;
    for (int j = 0; j < 16; j++) begin
      o[4*j +: 4] = inv ? inv_sbox(s[4*j +: 4]) : sbox(s[4*j +: 4]);
    end
    return o;
  endfunction

  // Row r occupies bits 63-16r..48-16r and rotates by 4r bits.
  function automatic logic [63:0] shift_rows(input logic [63:0] s);
    return {s[63:48], s[43:32], s[47:44], s[23:16], s[31:24], s[3:0], s[15:4]};
  endfunction

  function automatic logic [63:0] inv_shift_rows(input logic [63:0] s);
    return {s[63:48], s[35:32], s[47:36], s[23:16], s[31:24], s[11:0], s[15:12]};
  endfunction

  function automatic logic [63:0] rotl4(input logic [63:0] k);
    return {k[59:0], k[63:60]};
  endfunction

  function automatic logic [63:0] rotr4(input logic [63:0] k);
    return {k[3:0], k[63:4]};
  endfunction

  // Decryption starts from the last round key k_NUM_ROUNDS.
  if (DEC_ROT == 0) begin : g_rot0
    assign dec_key = key_in;
  end else begin : g_rotn
    assign dec_key = (key_in << DEC_ROT) | (key_in >> (64 - DEC_ROT));
  end

  assign load_key = mode ? dec_key : key_in;
  assign in_ready = !rst && ((fsm == IDLE) || ((fsm == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    rnd_state = state_q;
    rnd_key   = kreg_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (!mode_q) begin
        rnd_key   = rotl4(rnd_key);
        rnd_state = shift_rows(sub_nibbles(rnd_state, 1'b0)) ^ rnd_key;
      end else begin
        rnd_key   = rotr4(rnd_key);
        rnd_state = sub_nibbles(inv_shift_rows(rnd_state), 1'b1) ^ rnd_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      out_valid <= 1'b0;
      data_out  <= '0;
      state_q   <= '0;
      kreg_q    <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
    end else if (accept) begin
      fsm       <= RUN;
      out_valid <= 1'b0;
      state_q   <= data_in ^ load_key;
      kreg_q    <= load_key;
      mode_q    <= mode;
      cnt       <= '0;
    end else begin
      case (fsm)
        RUN: begin
          state_q <= rnd_state;
          kreg_q  <= rnd_key;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
            data_out  <= rnd_state;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_cipher_core.sv
// tb/tb_iterative_cipher_core.sv - randomized self-checking bench against a nibble-level cipher model
// Three instances: default, single round, and two rounds per clock.
module tb_iterative_cipher_core;

  localparam int NI = 3;
  localparam int NR [NI] = '{10, 1, 10};
  localparam int UR [NI] = '{1, 1, 2};
  localparam logic [3:0] SBOX [16] = '{4'h6, 4'hB, 4'h0, 4'h4, 4'hD, 4'h3, 4'hF, 4'h8,
                                       4'hA, 4'h2, 4'h7, 4'hC, 4'h5, 4'hE, 4'h1, 4'h9};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        mode      [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [63:0] data_in   [NI];
  logic [63:0] key_in    [NI];
  logic [63:0] data_out  [NI];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iterative_cipher_core #(.NUM_ROUNDS(NR[0]), .UNROLL(UR[0])) u_r10 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
    .data_in(data_in[0]), .key_in(key_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]));

  iterative_cipher_core #(.NUM_ROUNDS(NR[1]), .UNROLL(UR[1])) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
    .data_in(data_in[1]), .key_in(key_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]));

  iterative_cipher_core #(.NUM_ROUNDS(NR[2]), .UNROLL(UR[2])) u_u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]),
    .data_in(data_in[2]), .key_in(key_in[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(data_out[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: state as 16 nibbles, nibble 0 most significant.
  function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    logic [3:0]  v;
    o = '0;
    for (int j = 0; j < 16; j++) begin
      v = s[4*j +: 4];
      if (!inv) o[4*j +: 4] = SBOX[v];
      else for (int i = 0; i < 16; i++) if (SBOX[i] == v) o[4*j +: 4] = 4'(i);
    end
    return o;
  endfunction

  function automatic logic [63:0] m_shift(input logic [63:0] s, input bit inv);
    logic [3:0]  n [16];
    logic [63:0] o;
    int          src;
    for (int j = 0; j < 16; j++) n[j] = s[63-4*j -: 4];
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? 4*r + (c - r + 4) % 4 : 4*r + (c + r) % 4;
        o[63-4*(4*r+c) -: 4] = n[src];
      end
    end
    return o;
  endfunction

  function automatic logic [63:0] m_rk(input logic [63:0] k, input int i);
    int r;
    r = (4 * i) % 64;
    if (r == 0) return k;
    return (k << r) | (k >> (64 - r));
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [63:0] k, input int n);
    logic [63:0] s;
    s = p ^ k;
    for (int i = 1; i <= n; i++) s = m_shift(m_sub(s, 0), 0) ^ m_rk(k, i);
    return s;
  endfunction

  function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [63:0] k, input int n);
    logic [63:0] s;
    s = c ^ m_rk(k, n);
    for (int i = n - 1; i >= 0; i--) s = m_sub(m_shift(s, 1), 1) ^ m_rk(k, i);
    return s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge; returns the result and accept-to-out_valid latency in edges.
  task automatic do_req(input int idx, input logic m, input logic [63:0] d, input logic [63:0] k,
                        output logic [63:0] res, output int lat);
    int t_acc;
    int guard;
    in_valid[idx] = 1'b1;
    mode[idx]     = m;
    data_in[idx]  = d;
    key_in[idx]   = k;
    #1;
    guard = 0;
    while (!in_ready[idx] && guard < 20) begin @(negedge clk); #1; guard++; end
    check("accept_ready", in_ready[idx], 1);
    t_acc = cyc + 1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    mode[idx]     = ~m;
    data_in[idx]  = rnd64();
    key_in[idx]   = rnd64();
    #1;
    check("busy_ready", in_ready[idx], 0);
    guard = 0;
    while (!out_valid[idx] && guard < 64) begin @(negedge clk); #1; guard++; end
    lat = cyc - t_acc;
    res = data_out[idx];
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    #1;
    check("consumed", out_valid[idx], 0);
  endtask

  task automatic wait_valid(input int idx);
    int guard;
    guard = 0;
    while (!out_valid[idx] && guard < 64) begin @(negedge clk); #1; guard++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] res, p, k, d2, k2, e1, e2;
    int          lat, idx, t_acc, hits;
    logic        m;

    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; mode[i] = 1'b0; out_ready[i] = 1'b0;
      data_in[i] = '0; key_in[i] = '0;
    end

    rst = 1'b1;
    in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready[0], 0);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_data_out", data_out[0], 0);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready[0], 1);

    // First accept on the edge right after reset release.
    p = rnd64(); k = rnd64();
    do_req(0, 1'b0, p, k, res, lat);
    check("first_res", res, m_enc(p, k, 10));
    check("first_lat", lat, 10);

    @(negedge clk);
    do_req(1, 1'b0, 64'h0, 64'h1000_0000_0000_0000, res, lat);
    check("r1_enc_vec", res, 64'hB666_6666_6666_6667);
    check("r1_enc_lat", lat, 1);
    do_req(1, 1'b1, 64'h6666_6666_6666_6666, 64'h0, res, lat);
    check("r1_dec_vec", res, 64'h0);

    p = 64'h0123_4567_89AB_CDEF; k = 64'h0F1E_2D3C_4B5A_6978;
    do_req(0, 1'b0, p, k, res, lat);
    check("vec_enc", res, m_enc(p, k, 10));
    check("vec_enc_lat", lat, 10);
    do_req(0, 1'b1, res, k, res, lat);
    check("vec_roundtrip", res, p);
    check("vec_dec_lat", lat, 10);
    do_req(2, 1'b0, p, k, res, lat);
    check("u2_enc", res, m_enc(p, k, 10));
    check("u2_lat", lat, 5);

    for (int it = 0; it < 10; it++) begin
      idx = $urandom_range(0, NI - 1);
      m = 1'($urandom_range(0, 1));
      p = rnd64(); k = rnd64();
      do_req(idx, m, p, k, res, lat);
      check("rand_res", res, m ? m_dec(p, k, NR[idx]) : m_enc(p, k, NR[idx]));
      check("rand_lat", lat, NR[idx] / UR[idx]);
    end

    // Backpressure in DONE with a pending request, then consume and accept on the same edge.
    p = rnd64(); k = rnd64(); d2 = rnd64(); k2 = rnd64();
    e1 = m_enc(p, k, 10);
    e2 = m_dec(d2, k2, 10);
    in_valid[0] = 1'b1; mode[0] = 1'b0; data_in[0] = p; key_in[0] = k;
    #1;
    check("bp_ready", in_ready[0], 1);
    @(negedge clk);
    mode[0] = 1'b1; data_in[0] = d2; key_in[0] = k2;
    #1;
    wait_valid(0);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_data", data_out[0], e1);
      check("bp_hold_valid", out_valid[0], 1);
      check("bp_in_ready", in_ready[0], 0);
      @(negedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp_ready_follows", in_ready[0], 1);
    t_acc = cyc + 1;
    @(negedge clk);
    out_ready[0] = 1'b0; in_valid[0] = 1'b0; data_in[0] = rnd64();
    #1;
    check("bp_consumed", out_valid[0], 0);
    wait_valid(0);
    check("bp_next_lat", cyc - t_acc, 10);
    check("bp_next_res", data_out[0], e2);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset in the middle of a run.
    in_valid[0] = 1'b1; mode[0] = 1'b0; data_in[0] = rnd64(); key_in[0] = rnd64();
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid[0], 0);
    check("midrun_rst_ready", in_ready[0], 1);
    check("midrun_rst_data", data_out[0], 0);
    hits = 0;
    repeat (15) begin @(negedge clk); #1; if (out_valid[0]) hits++; end
    check("midrun_no_stale", hits, 0);

    // Reset during a DONE handshake that also offers a new request.
    p = rnd64(); k = rnd64();
    in_valid[0] = 1'b1; mode[0] = 1'b0; data_in[0] = p; key_in[0] = k;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    wait_valid(0);
    check("done_before_rst", data_out[0], m_enc(p, k, 10));
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; data_in[0] = rnd64(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready[0] = 1'b0; in_valid[0] = 1'b0;
    #1;
    check("done_rst_valid", out_valid[0], 0);
    check("done_rst_data", data_out[0], 0);
    hits = 0;
    repeat (15) begin @(negedge clk); #1; if (out_valid[0]) hits++; end
    check("done_rst_no_accept", hits, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
